// File: rtl/ram_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_if : single-port RAM access bus (select, direction, address, data)
// Revision : 1.0
// ----------------------------------------------------------------------------
interface ram_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
);
  logic                     rnw;
  logic                     cs;
  logic [ADDRESS_WIDTH-1:0] add;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [DATA_WIDTH-1:0]    rd_data;

  modport master (
    output rnw,
    output cs,
    output add,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  rnw,
    input  cs,
    input  add,
    input  wr_data,
    output rd_data
  );
endinterface
`default_nettype wire

// File: rtl/ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram : single-port synchronous byte RAM with registered 1-cycle read data
// Revision : 1.0
// ----------------------------------------------------------------------------
module ram #(
  parameter int RAM_SIZE      = 19200,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic clk,
  input  logic rst_n,
  ram_if.slave bus
);

  localparam int                 c_IDX_W    = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam logic [ADDRESS_WIDTH:0] c_RAM_SIZE = (ADDRESS_WIDTH+1)'(RAM_SIZE);

  logic [DATA_WIDTH-1:0] r_mem [0:RAM_SIZE-1];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_in_range;
  logic                  w_wr_en;
  logic                  w_rd_en;

  // One extra compare bit keeps a RAM_SIZE of 2**ADDRESS_WIDTH representable.
  assign w_in_range = ({1'b0, bus.add} < c_RAM_SIZE);
  assign w_idx      = bus.add[c_IDX_W-1:0];
  assign w_wr_en    = bus.cs & ~bus.rnw & w_in_range;
  assign w_rd_en    = bus.cs &  bus.rnw;

  // Array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (w_rd_en) begin
      r_rd_data <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

  assign bus.rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ram : directed scoreboard bench for the single-port byte RAM
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_ram;

  localparam int c_SIZE = 19200;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] model [int];
  logic [7:0] exp_q [$];
  logic [7:0] last_exp;

  ram_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) bus ();

  ram #(
    .RAM_SIZE      (c_SIZE),
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: rd_data=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  // Drive one access, predict rd_data after the edge, compare it 1 ns later.
  task automatic op(input string tag, input logic c, input logic r,
                    input logic [15:0] a, input logic [7:0] d);
    logic [7:0] e;
    logic [7:0] got;
    bus.cs      = c;
    bus.rnw     = r;
    bus.add     = a;
    bus.wr_data = d;
    if (c && r) begin
      if (int'(a) < c_SIZE) e = model.exists(int'(a)) ? model[int'(a)] : 8'hxx;
      else                  e = 8'h00;
    end else begin
      e = last_exp;
    end
    if (c && !r && int'(a) < c_SIZE) model[int'(a)] = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check(tag, bus.rd_data, got);
    last_exp = got;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.cs      = 1'b0;
    bus.rnw     = 1'b1;
    bus.add     = '0;
    bus.wr_data = '0;
    last_exp    = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("reset", bus.rd_data, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) op("idle_after_reset", 1'b0, 1'b1, 16'd0, 8'h00);

    op("wr0",     1'b1, 1'b0, 16'd0,     8'hA5);
    op("wr1",     1'b1, 1'b0, 16'd1,     8'h3C);
    op("wr_last", 1'b1, 1'b0, 16'd19199, 8'hFF);
    op("rd0",     1'b1, 1'b1, 16'd0,     8'h00);
    op("rd1",     1'b1, 1'b1, 16'd1,     8'h00);
    op("rd_last", 1'b1, 1'b1, 16'd19199, 8'h00);
    op("rd1_again", 1'b1, 1'b1, 16'd1,   8'h00);

    for (int i = 0; i < 3; i++) op("hold_idle", 1'b0, 1'b1, 16'd0, 8'h00);
    op("no_write_through", 1'b1, 1'b0, 16'd1, 8'h11);
    op("rd_after_wr",      1'b1, 1'b1, 16'd1, 8'h00);

    op("wr_oor",        1'b1, 1'b0, 16'd19200, 8'h77);
    op("rd_last_kept",  1'b1, 1'b1, 16'd19199, 8'h00);
    op("rd_oor",        1'b1, 1'b1, 16'd19200, 8'h00);
    op("hold_after_oor", 1'b0, 1'b1, 16'd0,    8'h00);
    op("rd_oor_max",    1'b1, 1'b1, 16'hFFFF,  8'h00);

    for (int i = 0; i < 192; i++) op("fill", 1'b1, 1'b0, 16'(i), 8'(i));
    for (int i = 0; i < 192; i++) op("stream", 1'b1, 1'b1, 16'(i), 8'h00);

    for (int i = 0; i < 10; i++) op("stream2", 1'b1, 1'b1, 16'(i), 8'h00);
    bus.add = 16'd10;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", bus.rd_data, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held", bus.rd_data, 8'h00);
    rst_n    = 1'b1;
    last_exp = 8'h00;
    op("rd0_after_reset", 1'b1, 1'b1, 16'd0, 8'h00);
    op("rd5_after_reset", 1'b1, 1'b1, 16'd5, 8'h00);
    op("idle_end",        1'b0, 1'b1, 16'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram.md
Name: ram

Overview:
- Single-port synchronous byte RAM. Used in pairs as the ping-pong line buffer of the JPEG encoder input stage.
- While one instance is written with incoming pixels, the other is read out in block order.
- All accesses are synchronous to one clock. Read data is registered with one-cycle latency.

Parameters:
- RAM_SIZE, 19200, number of words (valid addresses 0..RAM_SIZE-1).
- ADDRESS_WIDTH, 16, width of the add port.
- DATA_WIDTH, 8, word width of wr_data/rd_data.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rnw  input  1  1 = read access, 0 = write access (qualified by cs).
- cs  input  1  chip select; no access when 0.
- add  input  ADDRESS_WIDTH  word address.
- wr_data  input  DATA_WIDTH  write data.
- rd_data  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset:
  - rst_n low asynchronously forces rd_data to 0 and holds it at 0 while low.
  - Memory array contents are not cleared by reset and are undefined after power-up.
- Write: at a rising clk with cs=1, rnw=0 and add<RAM_SIZE, mem[add] <= wr_data.
  - rd_data is unchanged on a write cycle (no write-through).
- Read: at a rising clk with cs=1 and rnw=1, rd_data <= mem[add].
  - Data is visible one cycle after the address is presented.
- Idle: cs=0 performs no access, and rd_data holds its last value indefinitely.
- Out of range (add >= RAM_SIZE):
  - Writes are ignored; no other location is modified.
  - Reads load rd_data with 0.
- Consecutive reads to different addresses stream one word per cycle with fixed 1-cycle latency.
- A write followed next cycle by a read of the same address returns the newly written data.
- Single port: exactly one operation per cycle, selected by rnw. No simultaneous read+write case exists.
- add, rnw and wr_data are sampled only at the clock edge. Changes between edges have no effect.
- Reset asserted mid-operation:
  - rd_data clears immediately.
  - A write on the same edge as reset assertion has undefined effect on the array.
  - After rst_n deasserts, the first read returns the current array content.
- No combinational path from inputs to rd_data.

Test Plan:
- Reset then idle: rst_n=0 -> rd_data=0. Release rst_n, keep cs=0 for 5 cycles -> rd_data stays 0.
- Write/read back: write 0xA5@0, 0x3C@1, 0xFF@19199. Read 0, 1, 19199 back-to-back -> rd_data 0xA5, 0x3C, 0xFF, each one cycle after its address.
- Hold and no write-through:
  - After reading 0x3C, drive cs=0 for 3 cycles -> rd_data stays 0x3C.
  - Then write 0x11@1 -> rd_data still 0x3C.
  - Next read of 1 -> 0x11.
- Out of range:
  - Write 0x77@19200 -> ignored; reading 19199 -> still 0xFF.
  - Reading 19200 -> rd_data=0.
- Ping-pong streaming: fill addresses 0..191 with addr[7:0] using one write per cycle. Read 0..191 continuously -> rd_data equals address low byte with 1-cycle latency and no bubbles.
- Reset mid-stream: assert rst_n low during a read stream -> rd_data=0 immediately. After release, reading 0 -> prior contents (0x00 from the fill pattern).
